key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Consumes the debounced, glitch-free key level produced by the key debouncer and turns it into discrete key events: press, release, long-press, double-click and optional auto-repeat. Sits between the debouncer and the user-logic control FSMs (mode select, capture trigger). Each event is offered through a one-deep valid/ready holding register, and any event lost to back-pressure is recorded in a sticky flag.

## Interface
- ACTIVE_LEVEL, 1: key_level value that means "pressed".
- LONG_CYCLES, 50000000: cycles held before LONG fires (1 s at 50 MHz).
- DCLICK_CYCLES, 15000000: max release-to-press gap for DOUBLE.
- REPEAT_CYCLES, 10000000: auto-repeat period after LONG. Used only with the repeat macro.
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- key_level  in  1  debounced key level, synchronous to sys_clk.
- evt_valid  out  1  event pending.
- evt_code  out  3  0=PRESS, 1=RELEASE, 2=LONG, 3=DOUBLE, 4=REPEAT.
- evt_ready  in  1  consumer accepts event.
- evt_overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears evt_overflow.

## Operation
- Registers: prev_level, 32-bit cnt, state. Edge = key_level != prev_level. pressed = (key_level == ACTIVE_LEVEL).
- States and transitions:
  - IDLE (released): on press edge, emit PRESS, clear cnt, go to PRESSED.
  - PRESSED: cnt increments each cycle.
    - On release edge: emit RELEASE, clear cnt, go to GAP.
    - Else when cnt == LONG_CYCLES-1: emit LONG, clear cnt, go to HELD.
  - HELD: on release edge, emit RELEASE, clear cnt, go to GAP.
  - GAP (released): cnt increments each cycle.
    - On press edge with cnt < DCLICK_CYCLES: emit DOUBLE instead of PRESS, clear cnt, go to PRESSED. The long-press timer runs again.
    - When cnt == DCLICK_CYCLES-1 with no press: go to IDLE, no event.
- A release always yields RELEASE, including the release that follows a DOUBLE.
- A DOUBLE does not arm another double-click. The GAP entered after it still accepts a third press as DOUBLE; this is accepted behaviour.
- Output holding register:
  - A new event loads when evt_valid==0, or when evt_valid && evt_ready in the same cycle.
  - Otherwise the new event is dropped, the held event is kept, and evt_overflow is set.
- evt_overflow clears only on ovf_clr or reset. If set and ovf_clr occur in the same cycle, set wins.
- Counter saturation is never reached. The comparisons are exact equality, made before the increment.
- Any undefined state returns to IDLE with cnt cleared and no event.

## Timing
- Reset values:
  - evt_valid=0, evt_code=0, evt_overflow=0, state IDLE, cnt=0.
  - prev_level = ~ACTIVE_LEVEL.
  - Reset applies asynchronously and can occur mid-operation. A key already pressed at reset release is detected as a press edge on the first clock.
- Latency: edge sampled at clock N gives evt_valid=1 after clock N+1 (one register stage).
- LONG asserts exactly LONG_CYCLES clocks after the PRESS-edge clock.
- Handshake: evt_valid/evt_code stay stable until the cycle with evt_ready=1. evt_valid drops the next cycle unless a new event loads.
- evt_ready while evt_valid=0 is ignored.

## Configuration
- KEY_EVT_REPEAT_EN defined:
  - In HELD, cnt increments and emits REPEAT each time cnt == REPEAT_CYCLES-1, then clears.
  - Repeats continue until release.
- KEY_EVT_REPEAT_EN undefined:
  - HELD only waits for release. Code 4 is never produced.
  - REPEAT_CYCLES is unused.

## Structure
- Shared package key_evt_pkg holds the event code constants (PRESS..REPEAT), the state encoding (IDLE, PRESSED, HELD, GAP) and the 3-bit code width.
- One sub-module: key_evt_slot, the one-deep valid/ready holding register with overflow detection, reusable by other event sources.
- The FSM and counter live in the top.

## Test plan
Parameters for all scenarios: LONG=20, DCLICK=10, REPEAT=8.
- Press for 5 cycles, then release; evt_ready tied 1 -> PRESS at press+1, RELEASE at release+1. No LONG. evt_overflow=0.
- Hold for 30 cycles -> PRESS, then LONG exactly 20 clocks after the press edge, then RELEASE. With the macro: REPEAT at +8 after LONG. Without the macro: no REPEAT.
- Press 3, release 4, press 3, release -> PRESS, RELEASE, DOUBLE, RELEASE. Repeat with a 12-cycle gap -> PRESS, RELEASE, PRESS, RELEASE.
- evt_ready held 0, press then release -> PRESS held stable, RELEASE dropped, evt_overflow=1. ovf_clr pulse -> evt_overflow=0, PRESS still valid.
- Assert sys_rst_n low mid-HELD, with evt_valid=1 -> outputs 0 immediately without a clock edge. After release of reset with the key still pressed -> PRESS.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event decoder: event codes, FSM state encoding
// and the event code width.
package key_evt_pkg;

  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] evt_code_t;

  localparam evt_code_t EVT_PRESS   = 3'd0;
  localparam evt_code_t EVT_RELEASE = 3'd1;
  localparam evt_code_t EVT_LONG    = 3'd2;
  localparam evt_code_t EVT_DOUBLE  = 3'd3;
  localparam evt_code_t EVT_REPEAT  = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2,
    GAP     = 2'd3
  } state_t;

endpackage

// File: rtl/key_evt_slot.sv
// One-deep valid/ready holding register for event codes; a push that cannot be
// stored is dropped and recorded in a sticky overflow flag.
module key_evt_slot
  import key_evt_pkg::*;
#(
  parameter int CODE_W_P = CODE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_valid,
  input  logic [CODE_W_P-1:0] push_code,
  output logic                valid,
  output logic [CODE_W_P-1:0] code,
  input  logic                ready,
  input  logic                ovf_clr,
  output logic                overflow
);

  logic load;

  // A held event that is being consumed this cycle frees the slot for the push.
  assign load = push_valid && (!valid || ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      code     <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        code  <= push_code;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (push_valid && !load) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into PRESS/RELEASE/LONG/DOUBLE events through a
// one-deep holding slot. Define KEY_EVT_REPEAT_EN to enable auto-repeat in HELD.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter logic ACTIVE_LEVEL  = 1'b1,
  parameter int   LONG_CYCLES   = 50000000,
  parameter int   DCLICK_CYCLES = 15000000,
  parameter int   REPEAT_CYCLES = 10000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_level,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic              evt_overflow,
  input  logic              ovf_clr
);

  localparam logic [31:0] LONG_LAST   = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] DCLICK_LAST = 32'(DCLICK_CYCLES - 1);
  localparam logic [31:0] DCLICK_LIM  = 32'(DCLICK_CYCLES);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);
`endif

  if (LONG_CYCLES < 1 || DCLICK_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("key_event_decoder: cycle parameters must be at least 1");
  end

  logic        prev_level;
  logic [31:0] cnt;
  state_t      state;
  logic        vld_p0;
  evt_code_t   code_p0;

  logic edge_det;
  logic pressed;
  logic press_edge;
  logic release_edge;

  assign edge_det     = (key_level != prev_level);
  assign pressed      = (key_level == ACTIVE_LEVEL);
  assign press_edge   = edge_det && pressed;
  assign release_edge = edge_det && !pressed;

  // Stage p0: FSM decision registered as a one-cycle event strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_level <= ~ACTIVE_LEVEL;
      cnt        <= '0;
      state      <= IDLE;
      vld_p0     <= 1'b0;
      code_p0    <= EVT_PRESS;
    end else begin
      prev_level <= key_level;
      vld_p0     <= 1'b0;
      case (state)
        IDLE: begin
          if (press_edge) begin
            vld_p0  <= 1'b1;
            code_p0 <= EVT_PRESS;
            cnt     <= '0;
            state   <= PRESSED;
          end
        end
        PRESSED: begin
          if (release_edge) begin
            vld_p0  <= 1'b1;
            code_p0 <= EVT_RELEASE;
            cnt     <= '0;
            state   <= GAP;
          end else if (cnt == LONG_LAST) begin
            vld_p0  <= 1'b1;
            code_p0 <= EVT_LONG;
            cnt     <= '0;
            state   <= HELD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HELD: begin
          if (release_edge) begin
            vld_p0  <= 1'b1;
            code_p0 <= EVT_RELEASE;
            cnt     <= '0;
            state   <= GAP;
          end
`ifdef KEY_EVT_REPEAT_EN
          else if (cnt == REPEAT_LAST) begin
            vld_p0  <= 1'b1;
            code_p0 <= EVT_REPEAT;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
`endif
        end
        GAP: begin
          // A press inside the window re-arms the long-press timer as a DOUBLE.
          if (press_edge) begin
            vld_p0  <= 1'b1;
            code_p0 <= (cnt < DCLICK_LIM) ? EVT_DOUBLE : EVT_PRESS;
            cnt     <= '0;
            state   <= PRESSED;
          end else if (cnt == DCLICK_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage p1: holding slot presented to the consumer
  key_evt_slot #(
    .CODE_W_P (CODE_W)
  ) u_slot (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .push_valid (vld_p0),
    .push_code  (code_p0),
    .valid      (evt_valid),
    .code       (evt_code),
    .ready      (evt_ready),
    .ovf_clr    (ovf_clr),
    .overflow   (evt_overflow)
  );

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios plus random key/ready traffic
// compared every cycle against a timestamp-based event model.
module tb_key_event_decoder;
  import key_evt_pkg::*;

  localparam int LONG   = 20;
  localparam int DCLICK = 10;
  localparam int REP    = 8;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_level = 1'b0;
  logic       evt_ready = 1'b1;
  logic       ovf_clr   = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_overflow;

  int     n_assert = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: event source by timestamps, plus a one-deep consumer slot.
  bit         m_prev;
  longint     t_press, t_rel;
  bit         p_v;
  logic [2:0] p_c;
  bit         m_v;
  logic [2:0] m_c;
  bit         m_ovf;

  logic [2:0] log_code[$];
  longint     log_cyc[$];
  logic [2:0] exp_q[$];

  key_event_decoder #(
    .ACTIVE_LEVEL  (1'b1),
    .LONG_CYCLES   (LONG),
    .DCLICK_CYCLES (DCLICK),
    .REPEAT_CYCLES (REP)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_level    (key_level),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = 1'b0;
    t_press = cyc - 1000000;
    t_rel   = cyc - 1000000;
    p_v     = 1'b0;
    p_c     = 3'd0;
    m_v     = 1'b0;
    m_c     = 3'd0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_clock(input bit key_s, input bit ready_s, input bit clr_s);
    bit     acc;
    longint held;
    acc = p_v && (!m_v || ready_s);
    if (acc) begin
      m_v = 1'b1;
      m_c = p_c;
    end else if (m_v && ready_s) begin
      m_v = 1'b0;
    end
    if (p_v && !acc) m_ovf = 1'b1;
    else if (clr_s) m_ovf = 1'b0;
    p_v = 1'b0;
    if (key_s != m_prev) begin
      p_v = 1'b1;
      if (key_s) begin
        p_c     = (cyc - t_rel <= DCLICK) ? EVT_DOUBLE : EVT_PRESS;
        t_press = cyc;
      end else begin
        p_c   = EVT_RELEASE;
        t_rel = cyc;
      end
    end else if (key_s) begin
      held = cyc - t_press;
      if (held == LONG) begin
        p_v = 1'b1;
        p_c = EVT_LONG;
      end
`ifdef KEY_EVT_REPEAT_EN
      else if (held > LONG && (held - LONG) % REP == 0) begin
        p_v = 1'b1;
        p_c = EVT_REPEAT;
      end
`endif
    end
    m_prev = key_s;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      cyc++;
      model_clock(key_level, evt_ready, ovf_clr);
      #1;
      check("valid", 32'(evt_valid), 32'(m_v));
      if (m_v) check("code", 32'(evt_code), 32'(m_c));
      check("overflow", 32'(evt_overflow), 32'(m_ovf));
      if (evt_valid && evt_ready) begin
        log_code.push_back(evt_code);
        log_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic expect_seq(input string tag);
    check({tag, "_count"}, 32'(log_code.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_code.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), 32'(log_code[i]), 32'(exp_q[i]));
  endtask

  initial begin
    longint press_c, rel_c;
    int     len;

    // Reset state, no clock edge yet and then with clocks running.
    model_reset();
    #1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code", 32'(evt_code), 32'd0);
    check("rst_ovf", 32'(evt_overflow), 32'd0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(3);

    // Short click: PRESS then RELEASE, one cycle after each edge clock.
    log_code.delete(); log_cyc.delete();
    key_level = 1'b1; press_c = cyc + 1;
    step(5);
    key_level = 1'b0; rel_c = cyc + 1;
    step(15);
    exp_q = {EVT_PRESS, EVT_RELEASE};
    expect_seq("click");
    if (log_cyc.size() >= 2) begin
      check("click_press_lat", 32'(log_cyc[0] - press_c), 32'd1);
      check("click_rel_lat", 32'(log_cyc[1] - rel_c), 32'd1);
    end

    // Long hold of 30 cycles.
    log_code.delete(); log_cyc.delete();
    key_level = 1'b1;
    step(30);
    key_level = 1'b0;
    step(15);
`ifdef KEY_EVT_REPEAT_EN
    exp_q = {EVT_PRESS, EVT_LONG, EVT_REPEAT, EVT_RELEASE};
`else
    exp_q = {EVT_PRESS, EVT_LONG, EVT_RELEASE};
`endif
    expect_seq("hold");
    if (log_cyc.size() >= 2) check("long_delay", 32'(log_cyc[1] - log_cyc[0]), 32'(LONG));
`ifdef KEY_EVT_REPEAT_EN
    if (log_cyc.size() >= 3) check("repeat_delay", 32'(log_cyc[2] - log_cyc[1]), 32'(REP));
`endif

    // Double click inside the window, then the same pattern with a 12-cycle gap.
    log_code.delete(); log_cyc.delete();
    key_level = 1'b1; step(3);
    key_level = 1'b0; step(4);
    key_level = 1'b1; step(3);
    key_level = 1'b0; step(15);
    exp_q = {EVT_PRESS, EVT_RELEASE, EVT_DOUBLE, EVT_RELEASE};
    expect_seq("dclick");
    log_code.delete(); log_cyc.delete();
    key_level = 1'b1; step(3);
    key_level = 1'b0; step(12);
    key_level = 1'b1; step(3);
    key_level = 1'b0; step(15);
    exp_q = {EVT_PRESS, EVT_RELEASE, EVT_PRESS, EVT_RELEASE};
    expect_seq("slowclick");

    // Back-pressure: PRESS held, RELEASE dropped, then sticky flag cleared.
    evt_ready = 1'b0;
    key_level = 1'b1; step(5);
    key_level = 1'b0; step(3);
    check("bp_valid", 32'(evt_valid), 32'd1);
    check("bp_code", 32'(evt_code), 32'(EVT_PRESS));
    check("bp_ovf", 32'(evt_overflow), 32'd1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("clr_ovf", 32'(evt_overflow), 32'd0);
    check("clr_valid", 32'(evt_valid), 32'd1);
    check("clr_code", 32'(evt_code), 32'(EVT_PRESS));
    evt_ready = 1'b1; step(1);
    check("drain_valid", 32'(evt_valid), 32'd0);
    step(15);

    // Asynchronous reset while HELD with an event pending.
    evt_ready = 1'b0;
    key_level = 1'b1; step(25);
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_code", 32'(evt_code), 32'd0);
    check("arst_ovf", 32'(evt_overflow), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    evt_ready = 1'b1;
    log_code.delete(); log_cyc.delete();
    step(3);
    exp_q = {EVT_PRESS};
    expect_seq("post_rst");
    key_level = 1'b0; step(15);

    // Random key runs with random back-pressure and overflow clears.
    for (int r = 0; r < 160; r++) begin
      len = int'($urandom_range(1, 28));
      key_level = ~key_level;
      for (int i = 0; i < len; i++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        ovf_clr   = ($urandom_range(0, 15) == 0);
        step(1);
      end
    end
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    key_level = 1'b0;
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
